// File: rtl/display_scanner_pkg.sv
// Shared constants for the multiplexed seven-segment scanner.
// Glyphs are {a,b,c,d,e,f,g}, active-low.
package display_scanner_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPH_0 = 7'h01;
    localparam logic [6:0] GLYPH_1 = 7'h4F;
    localparam logic [6:0] GLYPH_2 = 7'h12;
    localparam logic [6:0] GLYPH_3 = 7'h06;
    localparam logic [6:0] GLYPH_4 = 7'h4C;
    localparam logic [6:0] GLYPH_5 = 7'h24;
    localparam logic [6:0] GLYPH_6 = 7'h20;
    localparam logic [6:0] GLYPH_7 = 7'h0F;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h04;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h60;
    localparam logic [6:0] GLYPH_C = 7'h31;
    localparam logic [6:0] GLYPH_D = 7'h42;
    localparam logic [6:0] GLYPH_E = 7'h30;
    localparam logic [6:0] GLYPH_F = 7'h38;

endpackage

// File: rtl/display_scanner_seg7_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg7_decoder
    import display_scanner_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        unique case (nibble)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            4'hF: glyph = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed seven-segment scanner with per-frame snapshot,
// leading-zero suppression, PWM brightness and anode dead band.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int SLOT_LOG2   = 16,
    parameter int BRIGHT_BITS = 4
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4*DIGITS-1:0]    data,
    input  logic [DIGITS-1:0]      dp_in,
    input  logic [DIGITS-1:0]      dig_en,
    input  logic                   lz_en,
    input  logic [BRIGHT_BITS-1:0] bright,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic [DIGITS-1:0]      an,
    output logic                   frame_start
);

    localparam int IW = $clog2(DIGITS);

    logic [SLOT_LOG2-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [4*DIGITS-1:0]    data_q, data_d;
    logic [DIGITS-1:0]      dpm_q, dpm_d;
    logic [DIGITS-1:0]      en_q, en_d;
    logic                   lz_q, lz_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic [DIGITS-1:0]      an_q, an_d;
    logic                   fs_q, fs_d;

    logic [DIGITS-1:0]      lz_blank;
    logic                   all_zero;
    logic [DIGITS-1:0]      show;
    logic                   cur_show;
    logic [3:0]             cur_nib;
    logic [6:0]             cur_glyph;
    logic [BRIGHT_BITS-1:0] t;
    logic                   pwm_on;
    logic                   dead;
    logic                   frame_begin;

    // A digit is suppressed when it and every digit above it are zero.
    always_comb begin
        lz_blank = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero    = all_zero && (data_q[4*i +: 4] == 4'h0);
            lz_blank[i] = lz_q && all_zero;
        end
    end

    assign show     = en_q & ~lz_blank;
    assign cur_show = show[idx_q];
    assign cur_nib  = data_q[4*int'(idx_q) +: 4];

    seg7_decoder u_dec (
        .nibble (cur_nib),
        .glyph  (cur_glyph)
    );

    always_comb begin
        frame_begin = (cnt_q == '0) && (idx_q == '0);
        t           = cnt_q[SLOT_LOG2-1 -: BRIGHT_BITS];
        pwm_on      = (&bright) || (t < bright);
        dead        = (cnt_q[SLOT_LOG2-1:1] == '0);

        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (&cnt_q) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        data_d = data_q;
        dpm_d  = dpm_q;
        en_d   = en_q;
        lz_d   = lz_q;
        if (frame_begin) begin
            data_d = data;
            dpm_d  = dp_in;
            en_d   = dig_en;
            lz_d   = lz_en;
        end

        an_d = '1;
        if (cur_show && pwm_on && !dead) begin
            an_d[idx_q] = 1'b0;
        end

        // Segments reload on count 1: inside the dead band, after the snapshot.
        seg_d = seg_q;
        dp_d  = dp_q;
        if (cnt_q == SLOT_LOG2'(1)) begin
            seg_d = cur_show ? cur_glyph : SEG_BLANK;
            dp_d  = !(cur_show && dpm_q[idx_q]);
        end

        fs_d = frame_begin;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            data_q <= '0;
            dpm_q  <= '0;
            en_q   <= '0;
            lz_q   <= 1'b0;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
            an_q   <= '1;
            fs_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            data_q <= data_d;
            dpm_q  <= dpm_d;
            en_q   <= en_d;
            lz_q   <= lz_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            an_q   <= an_d;
            fs_q   <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner: vector table plus
// tearing, reset and frame-period sequences.
module tb_display_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  dig_en = '0;
    logic        lz_en = 1'b0;
    logic [1:0]  bright = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int n_checks = 0;
    int n_fail = 0;
    bit mon_en = 0;
    logic [6:0] prev_seg = 7'h7F;

    display_scanner #(
        .DIGITS      (4),
        .SLOT_LOG2   (4),
        .BRIGHT_BITS (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data        (data),
        .dp_in       (dp_in),
        .dig_en      (dig_en),
        .lz_en       (lz_en),
        .bright      (bright),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dpi;
        logic [3:0]  en;
        logic        lz;
        logic [1:0]  br;
        int          n;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    vec_t vecs[$];

    logic [6:0] glyph_ref [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    function automatic vec_t mk(logic [15:0] d, logic [3:0] dpi,
                                logic [3:0] en, logic lz, logic [1:0] br,
                                int n, logic [3:0] a, logic [6:0] s,
                                logic p);
        vec_t v;
        v.data = d; v.dpi = dpi; v.en = en; v.lz = lz; v.br = br;
        v.n = n; v.an = a; v.seg = s; v.dp = p;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic adv(int k);
        repeat (k) @(posedge clk);
        @(negedge clk);
    endtask

    // Reset held for two cycles, released on a falling edge.
    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if ($countones(~an) > 1) begin
                n_fail++;
                $display("FAIL an_onehot: got %b expected at most one low", an);
            end
            if (an != 4'hF) begin
                n_checks++;
                if (seg != prev_seg) begin
                    n_fail++;
                    $display("FAIL seg_stable: got %0h expected %0h", seg, prev_seg);
                end
            end
            prev_seg = seg;
        end
    end

    initial begin
        int fs_count;
        bit found;

        // digit0..3 of 12AF are F, A, 2, 1
        vecs.push_back(mk(16'h12AF, 4'h0, 4'hF, 0, 2'd3,  0, 4'hF, 7'h7F, 1));
        vecs.push_back(mk(16'h12AF, 4'h0, 4'hF, 0, 2'd3,  1, 4'hF, 7'h38, 1));
        vecs.push_back(mk(16'h12AF, 4'h0, 4'hF, 0, 2'd3,  2, 4'hE, 7'h38, 1));
        vecs.push_back(mk(16'h12AF, 4'h0, 4'hF, 0, 2'd3, 16, 4'hF, 7'h38, 1));
        vecs.push_back(mk(16'h12AF, 4'h0, 4'hF, 0, 2'd3, 17, 4'hF, 7'h08, 1));
        vecs.push_back(mk(16'h12AF, 4'h0, 4'hF, 0, 2'd3, 21, 4'hD, 7'h08, 1));
        vecs.push_back(mk(16'h12AF, 4'h0, 4'hF, 0, 2'd3, 47, 4'hB, 7'h12, 1));
        vecs.push_back(mk(16'h12AF, 4'h0, 4'hF, 0, 2'd3, 56, 4'h7, 7'h4F, 1));
        vecs.push_back(mk(16'h0050, 4'hA, 4'hF, 1, 2'd3,  6, 4'hE, 7'h01, 1));
        vecs.push_back(mk(16'h0050, 4'hA, 4'hF, 1, 2'd3, 22, 4'hD, 7'h24, 0));
        vecs.push_back(mk(16'h0050, 4'hA, 4'hF, 1, 2'd3, 38, 4'hF, 7'h7F, 1));
        vecs.push_back(mk(16'h0050, 4'hA, 4'hF, 1, 2'd3, 54, 4'hF, 7'h7F, 1));
        vecs.push_back(mk(16'h0050, 4'h0, 4'hF, 0, 2'd3, 54, 4'h7, 7'h01, 1));
        vecs.push_back(mk(16'h0000, 4'h0, 4'hF, 1, 2'd3,  5, 4'hE, 7'h01, 1));
        vecs.push_back(mk(16'h0000, 4'h0, 4'hF, 1, 2'd3, 21, 4'hF, 7'h7F, 1));
        vecs.push_back(mk(16'h12AF, 4'h4, 4'hB, 0, 2'd3, 40, 4'hF, 7'h7F, 1));
        vecs.push_back(mk(16'h12AF, 4'h0, 4'hF, 0, 2'd1,  2, 4'hE, 7'h38, 1));
        vecs.push_back(mk(16'h12AF, 4'h0, 4'hF, 0, 2'd1,  3, 4'hE, 7'h38, 1));
        vecs.push_back(mk(16'h12AF, 4'h0, 4'hF, 0, 2'd1,  4, 4'hF, 7'h38, 1));
        vecs.push_back(mk(16'h12AF, 4'h0, 4'hF, 0, 2'd1, 18, 4'hD, 7'h08, 1));
        vecs.push_back(mk(16'h12AF, 4'h0, 4'hF, 0, 2'd1, 20, 4'hF, 7'h08, 1));
        vecs.push_back(mk(16'h12AF, 4'h0, 4'hF, 0, 2'd0,  5, 4'hF, 7'h38, 1));
        vecs.push_back(mk(16'h12AF, 4'h0, 4'hF, 0, 2'd2,  7, 4'hE, 7'h38, 1));
        vecs.push_back(mk(16'h12AF, 4'h0, 4'hF, 0, 2'd2,  8, 4'hF, 7'h38, 1));
        for (int h = 0; h < 16; h++) begin
            logic [3:0] nib;
            nib = 4'(h);
            vecs.push_back(mk({4{nib}}, 4'h1, 4'hF, 0, 2'd3, 2,
                              4'hE, glyph_ref[h], 0));
        end

        #2 reset = 1'b0;
        #1;
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_dp", 32'(dp), 32'h1);
        check("reset_an", 32'(an), 32'hF);
        check("reset_fs", 32'(frame_start), 32'h0);
        mon_en = 1;

        foreach (vecs[k]) begin
            data = vecs[k].data;
            dp_in = vecs[k].dpi;
            dig_en = vecs[k].en;
            lz_en = vecs[k].lz;
            bright = vecs[k].br;
            pulse_reset();
            adv(vecs[k].n + 1);
            check($sformatf("vec%0d_an", k), 32'(an), 32'(vecs[k].an));
            check($sformatf("vec%0d_seg", k), 32'(seg), 32'(vecs[k].seg));
            check($sformatf("vec%0d_dp", k), 32'(dp), 32'(vecs[k].dp));
        end

        // Data changes mid-frame must not tear the current frame.
        data = 16'h1111; dp_in = 4'h0; dig_en = 4'hF; lz_en = 0; bright = 2'd3;
        pulse_reset();
        adv(20);
        data = 16'h2222;
        adv(18);
        check("tear_d2", 32'(seg), 32'h4F);
        adv(16);
        check("tear_d3", 32'(seg), 32'h4F);
        adv(16);
        check("tear_next_d0", 32'(seg), 32'h12);
        adv(16);
        check("tear_next_d1", 32'(seg), 32'h12);

        // Asynchronous reset while digit 2 is lit.
        data = 16'h12AF;
        pulse_reset();
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            adv(1);
            if (an == 4'b1011) found = 1;
        end
        check("wait_an_1011", 32'(found), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("async_an", 32'(an), 32'hF);
        check("async_seg", 32'(seg), 32'h7F);
        check("async_fs", 32'(frame_start), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        fs_count = 0;
        for (int i = 0; i < 200; i++) begin
            adv(1);
            if (frame_start) fs_count++;
            if (i == 0 || i == 64 || i == 128)
                check($sformatf("fs_at_%0d", i), 32'(frame_start), 32'h1);
            if (i == 1 || i == 63)
                check($sformatf("fs_at_%0d", i), 32'(frame_start), 32'h0);
        end
        check("fs_count", 32'(fs_count), 32'd4);

        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
